// File: rtl/uart_rx_controller.sv
// Receive-side sequencer for character_recovery: idle-line gating,
// FWFT character FIFO, frame-error resync and saturating error counters.
module uart_rx_controller #(
  parameter int OVERSAMPLING = 16,
  parameter int IDLE_BITS    = 10,
  parameter int RESET_CYCLES = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   rx_i,
  output logic                   rec_rst_o,
  input  logic [7:0]             rec_char_i,
  input  logic                   rec_valid_i,
  input  logic                   rec_frame_error_i,
  output logic [7:0]             data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  input  logic                   clear_counts_i,
  output logic [COUNT_WIDTH-1:0] frame_err_count_o,
  output logic [COUNT_WIDTH-1:0] overrun_count_o,
  output logic [1:0]             state_o
);

  localparam int IDLE_MAX = OVERSAMPLING * IDLE_BITS - 1;
  localparam int IW = (IDLE_MAX > 0) ? $clog2(IDLE_MAX + 1) : 1;
  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    DISABLED   = 2'd0,
    HOLD_RESET = 2'd1,
    WAIT_IDLE  = 2'd2,
    RUN        = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic            fe_evt, push_req;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    idle_d   = idle_q;
    fe_evt   = 1'b0;
    push_req = 1'b0;
    if (!en_i) begin
      state_d = DISABLED;
    end else begin
      unique case (state_q)
        DISABLED: begin
          state_d = HOLD_RESET;
          hold_d  = HW'(RESET_CYCLES - 1);
        end
        HOLD_RESET: begin
          if (hold_q == '0) begin
            state_d = WAIT_IDLE;
            idle_d  = '0;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (!rx_i) idle_d = '0;
          else if (idle_q == IW'(IDLE_MAX)) state_d = RUN;
          else idle_d = idle_q + 1'b1;
        end
        RUN: begin
          // a frame error discards any character reported alongside it
          if (rec_frame_error_i) begin
            fe_evt  = 1'b1;
            state_d = HOLD_RESET;
            hold_d  = HW'(RESET_CYCLES - 1);
          end else begin
            push_req = rec_valid_i;
          end
        end
        default: state_d = DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= DISABLED;
      hold_q    <= '0;
      idle_q    <= '0;
      rec_rst_o <= 1'b1;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      idle_q    <= idle_d;
      rec_rst_o <= (state_d != RUN);
    end
  end

  assign state_o = state_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          full, pop, push, ovr_evt;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;
  assign pop     = valid_o & ready_i;
  assign push    = push_req & (~full | pop);
  assign ovr_evt = push_req & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= rec_char_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (!en_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_err_count_o <= '0;
      overrun_count_o   <= '0;
    end else if (clear_counts_i) begin
      frame_err_count_o <= '0;
      overrun_count_o   <= '0;
    end else begin
      if (fe_evt && !(&frame_err_count_o))
        frame_err_count_o <= frame_err_count_o + 1'b1;
      if (ovr_evt && !(&overrun_count_o))
        overrun_count_o <= overrun_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed self-checking bench for uart_rx_controller:
// startup sequencing, idle restart, FIFO flow, overrun, resync, saturation.
module tb_uart_rx_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, rx, rec_rst;
  logic [7:0] rec_char;
  logic       rec_valid, rec_fe;
  logic [7:0] data;
  logic       valid, ready, clear;
  logic [7:0] fe_cnt, ovr_cnt;
  logic [1:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_controller dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .en_i              (en),
    .rx_i              (rx),
    .rec_rst_o         (rec_rst),
    .rec_char_i        (rec_char),
    .rec_valid_i       (rec_valid),
    .rec_frame_error_i (rec_fe),
    .data_o            (data),
    .valid_o           (valid),
    .ready_i           (ready),
    .clear_counts_i    (clear),
    .frame_err_count_o (fe_cnt),
    .overrun_count_o   (ovr_cnt),
    .state_o           (state)
  );

  typedef struct {
    logic       rv;
    logic [7:0] ch;
    logic       fe;
    logic       rdy;
    logic [1:0] st;
    logic       rr;
    logic       v;
    logic [7:0] d;
    logic [7:0] fec;
    logic [7:0] ovc;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s);
    int i;
    for (i = 0; i < 400; i++) begin
      if (state == s) break;
      tick();
    end
    if (state != s) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_state: got %0d expected %0d", state, s);
    end
  endtask

  function automatic vec_t mk(logic rv, logic [7:0] ch, logic fe,
                              logic rdy, logic [1:0] st, logic rr,
                              logic v, logic [7:0] d, logic [7:0] fec,
                              logic [7:0] ovc);
    vec_t r;
    r.rv = rv; r.ch = ch; r.fe = fe; r.rdy = rdy;
    r.st = st; r.rr = rr; r.v = v; r.d = d;
    r.fec = fec; r.ovc = ovc;
    return r;
  endfunction

  initial begin
    int n;
    // rv ch fe rdy | st rr v d fec ovc  (state after the edge)
    tbl[0]  = mk(1, 8'h41, 0, 0, 3, 0, 1, 8'h41, 0, 0);
    tbl[1]  = mk(1, 8'h42, 0, 0, 3, 0, 1, 8'h41, 0, 0);
    tbl[2]  = mk(0, 8'h00, 0, 1, 3, 0, 1, 8'h42, 0, 0);
    tbl[3]  = mk(0, 8'h00, 0, 1, 3, 0, 0, 8'h00, 0, 0);
    tbl[4]  = mk(1, 8'h10, 0, 0, 3, 0, 1, 8'h10, 0, 0);
    tbl[5]  = mk(1, 8'h11, 0, 0, 3, 0, 1, 8'h10, 0, 0);
    tbl[6]  = mk(1, 8'h12, 0, 0, 3, 0, 1, 8'h10, 0, 0);
    tbl[7]  = mk(1, 8'h13, 0, 0, 3, 0, 1, 8'h10, 0, 0);
    tbl[8]  = mk(1, 8'h14, 0, 0, 3, 0, 1, 8'h10, 0, 1);
    tbl[9]  = mk(1, 8'h15, 0, 1, 3, 0, 1, 8'h11, 0, 1);
    tbl[10] = mk(1, 8'h99, 1, 0, 1, 1, 1, 8'h11, 1, 1);
    tbl[11] = mk(0, 8'h00, 0, 1, 1, 1, 1, 8'h12, 1, 1);
    tbl[12] = mk(0, 8'h00, 0, 1, 2, 1, 1, 8'h13, 1, 1);
    tbl[13] = mk(0, 8'h00, 0, 1, 2, 1, 1, 8'h15, 1, 1);
    tbl[14] = mk(0, 8'h00, 0, 1, 2, 1, 0, 8'h00, 1, 1);

    rst_n = 1'b0; en = 1'b0; rx = 1'b1;
    rec_char = 8'h00; rec_valid = 1'b0; rec_fe = 1'b0;
    ready = 1'b0; clear = 1'b0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_rec_rst", rec_rst, 1);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_fe_cnt", fe_cnt, 0);
    chk("rst_ovr_cnt", ovr_cnt, 0);

    // startup: 2 cycles HOLD_RESET, 160 cycles WAIT_IDLE
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state == 2'd1) n++;
      else break;
    end
    chk("hold_cycles", n, 2);
    chk("hold_rec_rst", rec_rst, 1);
    n = (state == 2'd2) ? 1 : 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (state == 2'd2) n++;
      else break;
    end
    chk("idle_cycles", n, 160);
    chk("run_state", state, 3);
    chk("run_rec_rst", rec_rst, 0);

    // idle counter restart on a low pulse
    en = 1'b0;
    tick();
    chk("dis_state", state, 0);
    en = 1'b1;
    wait_state(2'd2);
    repeat (100) tick();
    rx = 1'b0;
    tick();
    chk("pulse_state", state, 2);
    rx = 1'b1;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      n++;
      if (state == 2'd3) break;
    end
    chk("restart_cycles", n, 160);

    // FIFO flow, overrun, frame-error resync
    for (int i = 0; i < 15; i++) begin
      rec_valid = tbl[i].rv;
      rec_char  = tbl[i].ch;
      rec_fe    = tbl[i].fe;
      ready     = tbl[i].rdy;
      tick();
      chk($sformatf("v%0d_state", i), state, tbl[i].st);
      chk($sformatf("v%0d_rec_rst", i), rec_rst, tbl[i].rr);
      chk($sformatf("v%0d_valid", i), valid, tbl[i].v);
      chk($sformatf("v%0d_data", i), data, tbl[i].d);
      chk($sformatf("v%0d_fe_cnt", i), fe_cnt, tbl[i].fec);
      chk($sformatf("v%0d_ovr_cnt", i), ovr_cnt, tbl[i].ovc);
    end
    rec_valid = 1'b0; rec_fe = 1'b0; ready = 1'b0;

    // disable flushes FIFO but keeps counters
    wait_state(2'd3);
    rec_valid = 1'b1; rec_char = 8'h55;
    tick();
    rec_valid = 1'b0;
    chk("pre_flush_data", data, 8'h55);
    en = 1'b0;
    tick();
    chk("flush_state", state, 0);
    chk("flush_valid", valid, 0);
    chk("flush_data", data, 0);
    chk("flush_rec_rst", rec_rst, 1);
    chk("flush_fe_cnt", fe_cnt, 1);
    chk("flush_ovr_cnt", ovr_cnt, 1);
    en = 1'b1;

    // frame-error counter saturation
    for (int i = 0; i < 300; i++) begin
      wait_state(2'd3);
      rec_fe = 1'b1;
      tick();
      rec_fe = 1'b0;
    end
    chk("sat_fe_cnt", fe_cnt, 8'hff);
    chk("sat_state", state, 1);

    // clear beats a simultaneous increment
    wait_state(2'd3);
    rec_fe = 1'b1;
    clear = 1'b1;
    tick();
    rec_fe = 1'b0;
    clear = 1'b0;
    chk("clr_fe_cnt", fe_cnt, 0);
    chk("clr_ovr_cnt", ovr_cnt, 0);
    chk("clr_state", state, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
